// File: rtl/serial_servo_ctrl.sv
// -----------------------------------------------------------------------------
// serial_servo_ctrl
// Two-character serial command decoder driving N_CH hobby-servo PWM outputs.
// A command is a channel digit '0'+c followed by a position digit '0'+p.
// A valid command updates that channel's pending position and is answered
// with 'K'. A malformed command is answered with 'E'. Pending positions take
// effect only at a PWM period boundary, so a pulse is never cut short or
// stretched.
//
// Ports
//   clock        system clock
//   reset        asynchronous, active-high reset
//   zera         synchronous clear (same effect as reset, on the next edge)
//   rx_data      received character, qualified by rx_valid
//   rx_valid     one-cycle strobe for rx_data / rx_parity_ok
//   rx_parity_ok received character parity correct
//   tx_ready     transmitter idle
//   tx_start     one-cycle transmit request
//   tx_data      character to transmit (holds last value between responses)
//   pwm          servo pulse outputs, one per channel
//   db_estado    FSM state code (debug)
// -----------------------------------------------------------------------------
module serial_servo_ctrl #(
   parameter int N_CH          = 2,
   parameter int N_POS         = 4,
   parameter int N_BITS        = 7,
   parameter int PERIODO_CONTA = 1_000_000,
   parameter int PULSO_MIN     = 50_000,
   parameter int PULSO_PASSO   = 25_000
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              zera,
   input  logic [N_BITS-1:0] rx_data,
   input  logic              rx_valid,
   input  logic              rx_parity_ok,
   input  logic              tx_ready,
   output logic              tx_start,
   output logic [N_BITS-1:0] tx_data,
   output logic [N_CH-1:0]   pwm,
   output logic [1:0]        db_estado
);

   // One extra bit so the widest pulse width never wraps.
   localparam int CW = $clog2(PERIODO_CONTA) + 1;
   localparam logic [CW-1:0]     LAST_CNT = CW'(PERIODO_CONTA - 1);
   localparam logic [CW-1:0]     MIN_W    = CW'(PULSO_MIN);
   localparam logic [CW-1:0]     STEP_W   = CW'(PULSO_PASSO);
   localparam logic [N_BITS-1:0] CHAR_0   = N_BITS'(8'h30);
   localparam logic [N_BITS-1:0] CHAR_K   = N_BITS'(8'h4B);
   localparam logic [N_BITS-1:0] CHAR_E   = N_BITS'(8'h45);

   if (N_CH < 1 || N_CH > 8) begin : g_bad_nch
      $error("serial_servo_ctrl: N_CH must be 1..8");
   end
   if (N_POS < 1 || N_POS > 10) begin : g_bad_npos
      $error("serial_servo_ctrl: N_POS must be 1..10");
   end
   if (PULSO_MIN + (N_POS - 1) * PULSO_PASSO > PERIODO_CONTA) begin : g_bad_timing
      $error("serial_servo_ctrl: widest pulse exceeds PWM period");
   end

   typedef enum logic [1:0] {
      ESPERA_CANAL = 2'd0,
      ESPERA_POS   = 2'd1,
      RESPONDE     = 2'd2,
      ERRO         = 2'd3
   } estado_t;

   estado_t           r_estado;
   logic [2:0]        r_canal;
   logic [3:0]        r_pend  [N_CH];
   logic [3:0]        r_ativo [N_CH];
   logic [CW-1:0]     r_cnt;
   logic [N_BITS-1:0] r_tx_data;

   logic [N_BITS-1:0] w_off;
   logic              w_is_digit;
   logic              w_ch_ok;
   logic              w_pos_ok;
   logic              w_wrap;
   logic              w_resp;

   // Digit decode: offset from '0' is only meaningful when rx_data >= '0'.
   assign w_off      = rx_data - CHAR_0;
   assign w_is_digit = (rx_data >= CHAR_0);
   assign w_ch_ok    = rx_parity_ok && w_is_digit && (w_off < N_BITS'(N_CH));
   assign w_pos_ok   = rx_parity_ok && w_is_digit && (w_off < N_BITS'(N_POS));
   assign w_wrap     = (r_cnt == LAST_CNT);
   assign w_resp     = (r_estado == RESPONDE) || (r_estado == ERRO);

   // The request is raised in the first ready cycle of a response state, so a
   // byte accepted in cycle t can be answered in cycle t+1. zera cancels it.
   assign tx_start  = w_resp && tx_ready && !zera;
   assign tx_data   = (r_estado == RESPONDE) ? CHAR_K :
                      (r_estado == ERRO)     ? CHAR_E : r_tx_data;
   assign db_estado = r_estado;

   // Command FSM, shared period counter and pending/active position registers.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_estado  <= ESPERA_CANAL;
         r_canal   <= 3'd0;
         r_cnt     <= '0;
         r_tx_data <= '0;
         for (int i = 0; i < N_CH; i++) begin
            r_pend[i]  <= 4'd0;
            r_ativo[i] <= 4'd0;
         end
      end else if (zera) begin
         r_estado  <= ESPERA_CANAL;
         r_canal   <= 3'd0;
         r_cnt     <= '0;
         r_tx_data <= '0;
         for (int i = 0; i < N_CH; i++) begin
            r_pend[i]  <= 4'd0;
            r_ativo[i] <= 4'd0;
         end
      end else begin
         r_cnt <= w_wrap ? '0 : r_cnt + CW'(1);
         // Active positions change only at the period boundary.
         if (w_wrap) begin
            for (int i = 0; i < N_CH; i++) begin
               r_ativo[i] <= r_pend[i];
            end
         end
         case (r_estado)
            ESPERA_CANAL: begin
               if (rx_valid) begin
                  if (w_ch_ok) begin
                     r_canal  <= w_off[2:0];
                     r_estado <= ESPERA_POS;
                  end else begin
                     r_estado <= ERRO;
                  end
               end
            end
            ESPERA_POS: begin
               if (rx_valid) begin
                  if (w_pos_ok) begin
                     for (int i = 0; i < N_CH; i++) begin
                        if (r_canal == 3'(i)) begin
                           r_pend[i] <= w_off[3:0];
                        end
                     end
                     r_estado <= RESPONDE;
                  end else begin
                     r_estado <= ERRO;
                  end
               end
            end
            // rx_valid is deliberately ignored in both response states.
            RESPONDE: begin
               if (tx_ready) begin
                  r_tx_data <= CHAR_K;
                  r_estado  <= ESPERA_CANAL;
               end
            end
            ERRO: begin
               if (tx_ready) begin
                  r_tx_data <= CHAR_E;
                  r_estado  <= ESPERA_CANAL;
               end
            end
            default: r_estado <= ESPERA_CANAL;
         endcase
      end
   end

   // Pulse comparators; pwm is forced low while reset is asserted so the
   // first post-reset period starts cleanly at counter 0.
   always_comb begin
      pwm = '0;
      for (int i = 0; i < N_CH; i++) begin
         if (!reset && (r_cnt < (MIN_W + CW'(r_ativo[i]) * STEP_W))) begin
            pwm[i] = 1'b1;
         end else begin
            pwm[i] = 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_serial_servo_ctrl.sv
// Scoreboard bench for serial_servo_ctrl: the driver pushes expected
// responses/states with their cycle numbers, the monitor checks them plus a
// per-cycle PWM reference model.
module tb_serial_servo_ctrl;
   localparam int N_CH  = 2;
   localparam int N_POS = 4;
   localparam int NB    = 7;
   localparam int PER   = 100;
   localparam int PMIN  = 10;
   localparam int PSTEP = 5;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic          zera = 1'b0;
   logic [NB-1:0] rx_data = '0;
   logic          rx_valid = 1'b0;
   logic          rx_parity_ok = 1'b0;
   logic          tx_ready = 1'b1;
   logic          tx_start;
   logic [NB-1:0] tx_data;
   logic [N_CH-1:0] pwm;
   logic [1:0]    db_estado;

   serial_servo_ctrl #(
      .N_CH(N_CH), .N_POS(N_POS), .N_BITS(NB),
      .PERIODO_CONTA(PER), .PULSO_MIN(PMIN), .PULSO_PASSO(PSTEP)
   ) dut (
      .clock(clock), .reset(reset), .zera(zera),
      .rx_data(rx_data), .rx_valid(rx_valid), .rx_parity_ok(rx_parity_ok),
      .tx_ready(tx_ready), .tx_start(tx_start), .tx_data(tx_data),
      .pwm(pwm), .db_estado(db_estado)
   );

   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   typedef struct {
      int val;
      int cycle;
   } exp_t;

   exp_t tx_q[$];
   exp_t st_q[$];
   int   m_pend[N_CH];
   int   m_act[N_CH];
   int   m_cnt = 0;
   int   n_chk = 0;
   int   n_pass = 0;
   bit   done = 1'b0;

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
   endtask

   // Monitor: scoreboard pops, state checks and PWM reference model.
   always @(negedge clock) begin
      int   exp_pwm;
      exp_t e;
      if (reset) begin
         chk("pwm_in_reset", int'(pwm), 0);
         m_cnt = 0;
         for (int i = 0; i < N_CH; i++) m_act[i] = 0;
      end else begin
         exp_pwm = 0;
         for (int i = 0; i < N_CH; i++)
            if (m_cnt < PMIN + m_act[i] * PSTEP) exp_pwm = exp_pwm | (1 << i);
         chk("pwm", int'(pwm), exp_pwm);
         if (tx_start) begin
            if (tx_q.size() == 0) begin
               chk("tx_unexpected", 1, 0);
            end else begin
               e = tx_q.pop_front();
               chk("tx_data", int'(tx_data), e.val);
               chk("tx_cycle", cyc, e.cycle);
            end
         end
         while (st_q.size() > 0 && st_q[0].cycle <= cyc) begin
            e = st_q.pop_front();
            chk("db_estado", int'(db_estado), e.val);
         end
         if (zera) begin
            m_cnt = 0;
            for (int i = 0; i < N_CH; i++) m_act[i] = 0;
         end else if (m_cnt == PER - 1) begin
            m_cnt = 0;
            for (int i = 0; i < N_CH; i++) m_act[i] = m_pend[i];
         end else begin
            m_cnt++;
         end
      end
      if (done) begin
         chk("tx_queue_drained", tx_q.size(), 0);
         chk("state_queue_drained", st_q.size(), 0);
         $display("%0d/%0d checks passed", n_pass, n_chk);
         $finish;
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clock);
         #1;
      end
   endtask

   // Drive one character for one cycle; t is the cycle it is presented in.
   task automatic send(input logic [NB-1:0] ch, input logic pok, output int t);
      rx_data      = ch;
      rx_valid     = 1'b1;
      rx_parity_ok = pok;
      t            = cyc;
      tick(1);
      rx_valid     = 1'b0;
      rx_parity_ok = 1'b0;
   endtask

   task automatic exp_tx(input int v, input int c);
      tx_q.push_back('{v, c});
   endtask

   task automatic exp_st(input int v, input int c);
      st_q.push_back('{v, c});
   endtask

   initial begin
      int t;
      int z;
      for (int i = 0; i < N_CH; i++) m_pend[i] = 0;
      // Reset release: both channels 10 clocks wide from counter 0.
      tick(3);
      reset = 1'b0;
      exp_st(0, cyc);
      tick(205);

      // '1','3' -> 'K' one cycle later, channel 1 becomes 25 clocks wide.
      send(7'h31, 1'b1, t);
      exp_st(1, t + 1);
      send(7'h33, 1'b1, t);
      m_pend[1] = 3;
      exp_tx(8'h4B, t + 1);
      exp_st(2, t + 1);
      exp_st(0, t + 2);
      tick(250);

      // '5' as channel -> 'E'; then '0','2' -> 'K', channel 0 20 clocks.
      send(7'h35, 1'b1, t);
      exp_tx(8'h45, t + 1);
      exp_st(3, t + 1);
      exp_st(0, t + 2);
      tick(3);
      send(7'h30, 1'b1, t);
      send(7'h32, 1'b1, t);
      m_pend[0] = 2;
      exp_tx(8'h4B, t + 1);
      tick(220);

      // '0','1' with bad parity on the position -> 'E', channel 0 unchanged.
      send(7'h30, 1'b1, t);
      send(7'h31, 1'b0, t);
      exp_tx(8'h45, t + 1);
      exp_st(3, t + 1);
      tick(220);

      // tx_ready low for 30 cycles; a byte arriving meanwhile is dropped.
      tx_ready = 1'b0;
      send(7'h30, 1'b1, t);
      send(7'h33, 1'b1, t);
      m_pend[0] = 3;
      exp_tx(8'h4B, t + 31);
      exp_st(2, t + 15);
      tick(10);
      send(7'h31, 1'b1, z);
      exp_st(2, t + 20);
      tick(t + 31 - cyc);
      tx_ready = 1'b1;
      exp_st(0, t + 32);
      tick(220);

      // zera together with the position byte: byte dropped, no response.
      send(7'h31, 1'b1, t);
      exp_st(1, t + 1);
      zera         = 1'b1;
      rx_data      = 7'h32;
      rx_valid     = 1'b1;
      rx_parity_ok = 1'b1;
      z            = cyc;
      for (int i = 0; i < N_CH; i++) m_pend[i] = 0;
      tick(1);
      zera     = 1'b0;
      rx_valid = 1'b0;
      exp_st(0, z + 1);
      exp_st(0, z + 5);
      tick(220);

      // zera while a response waits for tx_ready: request cancelled.
      tx_ready = 1'b0;
      send(7'h30, 1'b1, t);
      send(7'h31, 1'b1, t);
      m_pend[0] = 1;
      exp_st(2, t + 2);
      tick(3);
      zera = 1'b1;
      z    = cyc;
      for (int i = 0; i < N_CH; i++) m_pend[i] = 0;
      tick(1);
      zera     = 1'b0;
      tx_ready = 1'b1;
      exp_st(0, z + 1);
      exp_st(0, z + 3);
      tick(150);

      for (int i = 0; i < 200 && (tx_q.size() > 0 || st_q.size() > 0); i++) tick(1);
      done = 1'b1;
   end
endmodule
